jt900h_memresp: RTL and testbench
=================================

Name: jt900h_memresp

Overview:
- Responder end of the CPU 16-bit RAM bus.
- Accepts ram_addr/ram_din/ram_we from the CPU-side RAM controller and returns ram_dout plus a data-valid flag, ram_ok.
- Decodes three regions:
  - on-chip work RAM (byte lanes);
  - an 8-bit-addressed I/O register window;
  - external ROM, reached through a req/ack handshake with a one-word line cache.
- Sits between the CPU core and the system memory map.

Parameters:
- RAM_AW, 12, work RAM size as byte-address width (2^RAM_AW bytes).
- RAM_BASE, 24'h004000, work RAM base; must be aligned to 2^RAM_AW.
- IO_BASE, 24'h000000, I/O window base, 256 bytes.
- ROM_BASE, 24'hFF0000, ROM base; ROM spans ROM_BASE to 24'hFFFFFF.

Ports:
- rst  input  1  asynchronous reset, active high
- clk  input  1  clock
- cen  input  1  clock enable shared with the CPU; writes commit only on cen
- ram_addr  input  24  byte address from the CPU; bit 0 is ignored for the word returned
- ram_din  input  16  write data; high byte goes to odd address
- ram_we  input  2  byte write mask: [1] odd/high byte, [0] even/low byte
- ram_dout  output  16  read word for {ram_addr[23:1],0}
- ram_ok  output  1  high when ram_dout matches the current ram_addr
- io_addr  output  8  I/O register byte address
- io_dout  output  8  I/O write data
- io_we  output  1  one-cen-cycle I/O write strobe
- io_din  input  16  I/O read word for {io_addr[7:1],0}
- rom_addr  output  23  ROM word address
- rom_cs  output  1  ROM request, held until ack
- rom_ok  input  1  ROM data valid / ack
- rom_data  input  16  ROM word

Behaviour:
Reset values:
- ram_dout=0, ram_ok=0, io_we=0, io_addr=0, io_dout=0, rom_cs=0, rom_addr=0.
- ROM cache invalid; FSM in IDLE.
- RAM contents not reset.

Region decode (combinational on ram_addr):
- IO: addr[23:8]==IO_BASE[23:8].
- RAM: addr[23:RAM_AW]==RAM_BASE[23:RAM_AW].
- ROM: addr>=ROM_BASE.
- Otherwise unmapped. Priority on overlap is IO, then RAM, then ROM.

Work RAM:
- Two byte-wide arrays, even and odd.
- Read is registered on every clk, not gated by cen: ram_dout is valid one clk after ram_addr settles.
- The CPU runs cen at half rate or slower, so a zero-wait read holds.
- A write on cen with ram_we[n]=1 updates that lane.
- Read-during-write on the same word returns the new data on the next clk (write-first per lane).

I/O:
- Write: on cen with ram_we!=0 in IO, io_we=1 for one cen cycle, io_addr=ram_addr[7:0].
  - io_dout is the selected lane: ram_din[15:8] if addr[0] else ram_din[7:0].
  - If ram_we==2'b11, io_dout is the even byte and io_addr is forced even; the odd byte is dropped.
- Read: io_addr follows ram_addr[7:0] every clk; ram_dout<=io_din one clk later.

ROM FSM, states IDLE, REQ, FILL:
- Cache holds tag[23:1], data[15:0] and valid.
- IDLE:
  - If ROM region and valid and tag==addr[23:1] (hit): ram_dout<=data, ram_ok=1.
  - On a miss: rom_addr<=addr[23:1], rom_cs<=1, go to REQ, ram_ok=0.
- REQ: wait for rom_ok=1. Then data<=rom_data, tag<=rom_addr, valid<=1, rom_cs<=0, go to FILL.
- FILL: one clk. Return to IDLE; the hit is re-evaluated there.
- If ram_addr changes during REQ, the fetch completes anyway (no abort). The new address is handled from IDLE.
- rom_ok while rom_cs=0 is ignored.
- Writes to the ROM region are discarded and do not touch the cache.

ram_ok:
- Registered.
- 1 when the previous-clk address (word bits) equals the current one and that region's data is loaded.
- Falls to 0 for one clk after any change of ram_addr[23:1].
- RAM and IO: ok after 1 clk.
- ROM hit: ok after 1 clk. ROM miss: ok after ack+2 clk.
- Unmapped: ram_dout=16'hFFFF, ram_ok as for RAM.
- ram_we!=0 leaves ram_ok unchanged.

Reset mid-fetch: rom_cs drops immediately and the cache is invalidated.

Test Plan:
- RAM word write then read: we=11 din=A55A at RAM_BASE; read same -> dout=A55A, ram_ok=1 one clk after address settles.
- Byte lanes: we=10 din=12xx to RAM_BASE+1, then we=01 din=xx34 to RAM_BASE -> read RAM_BASE returns 1234; odd-only write leaves the even byte intact.
- IO write: we=10 din=BEEF at IO_BASE+5 -> io_we pulses one cen cycle, io_addr=05, io_dout=BE; reading IO_BASE+4 with io_din=CAFE returns CAFE.
- ROM miss then hit: read FF0010 with rom_ok 5 clk after rom_cs -> rom_addr=7F8008, ram_ok low until fill, dout=rom_data. Reading FF0011 next is a hit: no rom_cs, ok in 1 clk.
- Address change mid-fetch: move FF0010 to FF0020 during REQ -> first fetch completes and caches 7F8008; a second request is then issued for 7F8010.
- Reset during REQ: assert rst -> rom_cs=0 at once; after release, the same address misses again.

Source files
------------

// File: rtl/jt900h_memresp.sv
// jt900h_memresp: responder end of the CPU 16-bit RAM bus.
// Decodes an 8-bit I/O window, on-chip byte-lane work RAM and external ROM
// (reached through a req/ack handshake with a one-word line cache), and
// returns the read word together with a registered data-valid flag.
module jt900h_memresp #(
    parameter int          RAM_AW   = 12,
    parameter logic [23:0] RAM_BASE = 24'h004000,
    parameter logic [23:0] IO_BASE  = 24'h000000,
    parameter logic [23:0] ROM_BASE = 24'hFF0000
) (
    input  logic        rst_i,
    input  logic        clk_i,
    input  logic        cen_i,
    input  logic [23:0] ram_addr_i,
    input  logic [15:0] ram_din_i,
    input  logic [1:0]  ram_we_i,
    output logic [15:0] ram_dout_o,
    output logic        ram_ok_o,
    output logic [7:0]  io_addr_o,
    output logic [7:0]  io_dout_o,
    output logic        io_we_o,
    input  logic [15:0] io_din_i,
    output logic [22:0] rom_addr_o,
    output logic        rom_cs_o,
    input  logic        rom_ok_i,
    input  logic [15:0] rom_data_i
);
    localparam int RAM_WORDS = 2 ** (RAM_AW - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_FILL} state_t;

    logic [22:0]       word;
    logic [RAM_AW-2:0] ram_idx;
    logic              wr_any;
    logic              is_io;
    logic              is_ram;
    logic              is_rom;

    state_t            state_q;
    logic              valid_q;
    logic [22:0]       tag_q;
    logic [15:0]       data_q;
    logic              rom_cs_q;
    logic [22:0]       rom_addr_q;
    logic              cache_match;
    logic              rom_hit;

    logic [7:0]        rd_lane_q [2];
    logic              sel_ram_q;
    logic [15:0]       dout_q;
    logic              ok_q;
    logic              ok_d;
    logic [22:0]       last_word_q;
    logic              io_we_q;
    logic [7:0]        io_addr_q;
    logic [7:0]        io_addr_d;
    logic [7:0]        io_dout_q;
    logic [7:0]        io_dout_d;

    // Region decode on the live address; IO wins over RAM, RAM over ROM
    always_comb begin
        word    = ram_addr_i[23:1];
        ram_idx = ram_addr_i[RAM_AW-1:1];
        wr_any  = |ram_we_i;
        is_io   = ram_addr_i[23:8] == IO_BASE[23:8];
        is_ram  = !is_io && (ram_addr_i[23:RAM_AW] == RAM_BASE[23:RAM_AW]);
        is_rom  = !is_io && !is_ram && (ram_addr_i >= ROM_BASE);
    end

    assign cache_match = valid_q && (tag_q == word);
    assign rom_hit     = (state_q == ST_IDLE) && cache_match;

    // Work RAM: one byte-wide array per lane, write-first registered read
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [7:0] mem [RAM_WORDS];
        logic       wr_en;

        assign wr_en = cen_i && is_ram && ram_we_i[gi];

        // Lane write on cen; the read port runs every clk
        always_ff @(posedge clk_i) begin
            if (wr_en) begin
                mem[ram_idx]  <= ram_din_i[gi*8 +: 8];
                rd_lane_q[gi] <= ram_din_i[gi*8 +: 8];
            end else begin
                rd_lane_q[gi] <= mem[ram_idx];
            end
        end
    end

    // Next-state for data-valid, I/O address and I/O write byte
    always_comb begin
        ok_d = ok_q;
        if (!wr_any) begin
            if (word != last_word_q) begin
                ok_d = 1'b0;
            end else if (is_rom) begin
                ok_d = rom_hit;
            end else begin
                ok_d = 1'b1;
            end
        end

        io_addr_d = ram_addr_i[7:0];
        if (is_io && (ram_we_i == 2'b11)) begin
            io_addr_d[0] = 1'b0;
        end

        if (ram_we_i == 2'b11) begin
            io_dout_d = ram_din_i[7:0];
        end else if (ram_addr_i[0]) begin
            io_dout_d = ram_din_i[15:8];
        end else begin
            io_dout_d = ram_din_i[7:0];
        end
    end

    // ROM line-cache FSM: miss in IDLE raises rom_cs until ack, FILL settles one clk
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            tag_q      <= '0;
            data_q     <= '0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_rom && !wr_any && !cache_match) begin
                        rom_addr_q <= word;
                        rom_cs_q   <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (rom_ok_i) begin
                        data_q   <= rom_data_i;
                        tag_q    <= rom_addr_q;
                        valid_q  <= 1'b1;
                        rom_cs_q <= 1'b0;
                        state_q  <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data, data-valid tracking and I/O strobes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dout_q      <= '0;
            sel_ram_q   <= 1'b0;
            ok_q        <= 1'b0;
            last_word_q <= '0;
            io_we_q     <= 1'b0;
            io_addr_q   <= '0;
            io_dout_q   <= '0;
        end else begin
            last_word_q <= word;
            ok_q        <= ok_d;
            io_addr_q   <= io_addr_d;
            sel_ram_q   <= is_ram;
            if (is_io) begin
                dout_q <= io_din_i;
            end else if (is_rom) begin
                if (rom_hit) begin
                    dout_q <= data_q;
                end
            end else if (!is_ram) begin
                dout_q <= 16'hFFFF;
            end
            if (cen_i) begin
                io_we_q <= is_io && wr_any;
                if (is_io && wr_any) begin
                    io_dout_q <= io_dout_d;
                end
            end
        end
    end

    assign ram_dout_o = sel_ram_q ? {rd_lane_q[1], rd_lane_q[0]} : dout_q;
    assign ram_ok_o   = ok_q;
    assign io_addr_o  = io_addr_q;
    assign io_dout_o  = io_dout_q;
    assign io_we_o    = io_we_q;
    assign rom_addr_o = rom_addr_q;
    assign rom_cs_o   = rom_cs_q;

endmodule

// File: tb/tb_jt900h_memresp.sv
// tb_jt900h_memresp: randomized bench for jt900h_memresp with a byte-level
// RAM model, a one-word ROM cache model and a ROM responder with variable latency.
module tb_jt900h_memresp;
    localparam logic [23:0] RAM_BASE = 24'h004000;
    localparam logic [23:0] IO_BASE  = 24'h000000;
    localparam logic [23:0] ROM_BASE = 24'hFF0000;

    typedef enum {R_IO, R_RAM, R_ROM, R_NONE} region_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cen_i = 1'b0;
    logic [23:0] ram_addr_i = 24'h100000;
    logic [15:0] ram_din_i = '0;
    logic [1:0]  ram_we_i = '0;
    logic [15:0] ram_dout_o;
    logic        ram_ok_o;
    logic [7:0]  io_addr_o;
    logic [7:0]  io_dout_o;
    logic        io_we_o;
    logic [15:0] io_din_i = 16'hCAFE;
    logic [22:0] rom_addr_o;
    logic        rom_cs_o;
    logic        rom_ok_i;
    logic [15:0] rom_data_i;

    int          n_vec = 0;
    int          n_err = 0;
    int          rom_lat = 3;
    int          n_fetch = 0;
    logic [22:0] fetch_q [$];

    logic [7:0]  mram [4096];
    logic        mvalid = 1'b0;
    logic [22:0] mtag = '0;
    logic [23:0] mprev = 24'h800000;

    jt900h_memresp dut (
        .rst_i      (rst_i),
        .clk_i      (clk_i),
        .cen_i      (cen_i),
        .ram_addr_i (ram_addr_i),
        .ram_din_i  (ram_din_i),
        .ram_we_i   (ram_we_i),
        .ram_dout_o (ram_dout_o),
        .ram_ok_o   (ram_ok_o),
        .io_addr_o  (io_addr_o),
        .io_dout_o  (io_dout_o),
        .io_we_o    (io_we_o),
        .io_din_i   (io_din_i),
        .rom_addr_o (rom_addr_o),
        .rom_cs_o   (rom_cs_o),
        .rom_ok_i   (rom_ok_i),
        .rom_data_i (rom_data_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] rom_word(logic [22:0] w);
        logic [22:0] p;
        p = w * 23'd40503;
        return p[15:0] ^ 16'h5A5A;
    endfunction

    function automatic region_t region_of(logic [23:0] a);
        if (a >= IO_BASE && a < IO_BASE + 24'd256) return R_IO;
        if (a >= RAM_BASE && a < RAM_BASE + 24'd4096) return R_RAM;
        if (a >= ROM_BASE) return R_ROM;
        return R_NONE;
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; cen alternates every clk
    task automatic tick();
        @(negedge clk_i);
        #1;
        cen_i = ~cen_i;
    endtask

    // ROM responder: acks rom_lat clks after rom_cs, babbles while idle
    initial begin : responder
        int   cnt;
        logic cs_prev;
        cnt = 0;
        cs_prev = 1'b0;
        rom_ok_i = 1'b0;
        rom_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (rom_cs_o && !cs_prev) begin
                n_fetch++;
                fetch_q.push_back(rom_addr_o);
            end
            cs_prev = rom_cs_o;
            if (rom_cs_o) begin
                cnt++;
                rom_ok_i = (cnt >= rom_lat);
                rom_data_i = rom_ok_i ? rom_word(rom_addr_o) : 16'($urandom);
            end else begin
                cnt = 0;
                rom_ok_i = ($urandom_range(0, 3) == 0);
                rom_data_i = 16'($urandom);
            end
        end
    end

    task automatic wr(logic [23:0] a, logic [15:0] d, logic [1:0] we);
        int idx;
        ram_addr_i = a;
        ram_din_i = d;
        ram_we_i = we;
        if (!cen_i) tick();
        tick();
        if (region_of(a) == R_RAM) begin
            idx = int'(a - RAM_BASE);
            if (we[0]) mram[idx & ~1] = d[7:0];
            if (we[1]) mram[idx | 1] = d[15:8];
        end
        mprev = {1'b0, a[23:1]};
        ram_we_i = 2'b00;
        $display("wr  %06h we=%b din=%04h", a, we, d);
    endtask

    task automatic rd(logic [23:0] a);
        region_t     r;
        bit          same;
        bit          miss;
        int          n;
        int          f0;
        int          exp_n;
        int          idx;
        logic [15:0] exp;
        r = region_of(a);
        same = (mprev == {1'b0, a[23:1]});
        ram_addr_i = a;
        ram_we_i = 2'b00;
        if (r == R_ROM) begin
            miss = !(mvalid && mtag == a[23:1]);
            exp_n = miss ? rom_lat + 3 : (same ? 1 : 2);
            f0 = n_fetch;
            n = 0;
            do begin
                tick();
                n++;
            end while (!ram_ok_o && n < 60);
            check_eq("rom_cycles", n, exp_n);
            check_eq("rom_dout", ram_dout_o, rom_word(a[23:1]));
            check_eq("rom_fetches", n_fetch - f0, miss ? 1 : 0);
            if (miss && fetch_q.size() > 0) check_eq("rom_addr", fetch_q[$], a[23:1]);
            mvalid = 1'b1;
            mtag = a[23:1];
        end else begin
            if (r == R_IO) exp = io_din_i;
            else if (r == R_RAM) begin
                idx = int'(a - RAM_BASE);
                exp = {mram[idx | 1], mram[idx & ~1]};
            end else exp = 16'hFFFF;
            tick();
            check_eq("ok_first_clk", ram_ok_o, same);
            if (r == R_RAM) check_eq("ram_dout_1clk", ram_dout_o, exp);
            if (r == R_IO) check_eq("io_addr_follow", io_addr_o, a[7:0]);
            tick();
            check_eq("ok_settled", ram_ok_o, 1'b1);
            check_eq("rd_dout", ram_dout_o, exp);
        end
        mprev = {1'b0, a[23:1]};
        $display("rd  %06h -> %04h ok=%0d", a, ram_dout_o, ram_ok_o);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int          f0;
        int          n;
        int          sel;
        logic [23:0] a;

        // Reset state
        repeat (3) tick();
        check_eq("rst_dout", ram_dout_o, 16'h0000);
        check_eq("rst_ok", ram_ok_o, 1'b0);
        check_eq("rst_io_we", io_we_o, 1'b0);
        check_eq("rst_io_addr", io_addr_o, 8'h00);
        check_eq("rst_io_dout", io_dout_o, 8'h00);
        check_eq("rst_rom_cs", rom_cs_o, 1'b0);
        check_eq("rst_rom_addr", rom_addr_o, 23'h0);
        rst_i = 1'b0;
        mprev = 24'h800000;

        // RAM word write then read
        wr(RAM_BASE, 16'hA55A, 2'b11);
        rd(RAM_BASE);
        check_eq("ram_word", ram_dout_o, 16'hA55A);

        // Byte lanes
        wr(RAM_BASE + 24'd1, 16'h12FF, 2'b10);
        wr(RAM_BASE, 16'hEE34, 2'b01);
        rd(RAM_BASE);
        check_eq("ram_lanes", ram_dout_o, 16'h1234);
        wr(RAM_BASE + 24'd1, 16'h77AA, 2'b10);
        rd(RAM_BASE);
        check_eq("ram_odd_only", ram_dout_o, 16'h7734);

        // I/O write strobe and byte select
        wr(IO_BASE + 24'd5, 16'hBEEF, 2'b10);
        check_eq("io_we_set", io_we_o, 1'b1);
        check_eq("io_wr_addr", io_addr_o, 8'h05);
        check_eq("io_wr_dout", io_dout_o, 8'hBE);
        tick();
        check_eq("io_we_hold", io_we_o, 1'b1);
        tick();
        check_eq("io_we_drop", io_we_o, 1'b0);
        wr(IO_BASE + 24'd7, 16'h1122, 2'b11);
        check_eq("io_wr16_addr", io_addr_o, 8'h06);
        check_eq("io_wr16_dout", io_dout_o, 8'h22);
        io_din_i = 16'hCAFE;
        rd(IO_BASE + 24'd4);
        check_eq("io_rd", ram_dout_o, 16'hCAFE);

        // ROM miss then hit in the same word
        rom_lat = 5;
        rd(24'hFF0010);
        rd(24'hFF0011);
        check_eq("rom_hit_no_cs", rom_cs_o, 1'b0);

        // Address moves while a fetch is outstanding
        rd(24'hFF0030);
        f0 = n_fetch;
        ram_addr_i = 24'hFF0010;
        tick();
        tick();
        check_eq("midfetch_cs", rom_cs_o, 1'b1);
        ram_addr_i = 24'hFF0020;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ram_ok_o && n < 60);
        check_eq("midfetch_fetches", n_fetch - f0, 2);
        if (fetch_q.size() >= 2) begin
            check_eq("midfetch_first", fetch_q[$-1], 23'h7F8008);
            check_eq("midfetch_second", fetch_q[$], 23'h7F8010);
        end else begin
            check_eq("midfetch_qsize", fetch_q.size(), 2);
        end
        check_eq("midfetch_dout", ram_dout_o, rom_word(23'h7F8010));
        mvalid = 1'b1;
        mtag = 23'h7F8010;
        mprev = {1'b0, 23'h7F8010};
        $display("rd  FF0010->FF0020 mid-fetch -> %04h ok=%0d", ram_dout_o, ram_ok_o);

        // Reset during REQ
        rom_lat = 8;
        ram_addr_i = 24'hFF0040;
        tick();
        tick();
        check_eq("rstreq_cs_before", rom_cs_o, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("rstreq_cs", rom_cs_o, 1'b0);
        check_eq("rstreq_ok", ram_ok_o, 1'b0);
        check_eq("rstreq_dout", ram_dout_o, 16'h0000);
        tick();
        rst_i = 1'b0;
        mvalid = 1'b0;
        mprev = 24'h800000;
        $display("rst during fetch of FF0040");
        rom_lat = 2;
        rd(24'hFF0040);

        // Unmapped read, and a ROM write that must not touch the cache
        rd(24'h123456);
        wr(24'hFF0040, 16'hDEAD, 2'b11);
        rd(24'hFF0040);

        // Randomized traffic
        for (int i = 0; i < 32; i++) wr(RAM_BASE + 24'(2 * i), 16'($urandom), 2'b11);
        for (int k = 0; k < 160; k++) begin
            sel = $urandom_range(0, 19);
            if (sel < 7) begin
                wr(RAM_BASE + 24'($urandom_range(0, 63)), 16'($urandom), 2'($urandom_range(1, 3)));
            end else if (sel < 12) begin
                rd(RAM_BASE + 24'($urandom_range(0, 63)));
            end else if (sel < 14) begin
                io_din_i = 16'($urandom);
                rd(IO_BASE + 24'($urandom_range(0, 255)));
            end else if (sel < 15) begin
                rd(24'h100000 + 24'($urandom_range(0, 24'hFFFFF)));
            end else if (sel < 16) begin
                a = ROM_BASE + 24'($urandom_range(0, 15));
                wr(a, 16'($urandom), 2'($urandom_range(1, 3)));
            end else begin
                rom_lat = $urandom_range(1, 6);
                rd(ROM_BASE + 24'($urandom_range(0, 15)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
